// File: rtl/srg_iterative_alu_if.sv
`default_nettype none
// ============================================================================
// Module  : srg_iterative_alu_if
// Brief   : Start/Ready/Done request and result bundle for srg_iterative_alu.
// Revision: 1.0 - initial release
// ============================================================================
interface srg_iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       OperationSelect;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Overflow;
  logic             Zero;

  modport master (
    output Start, OperationSelect, A, B,
    input  Ready, Done, Result, ResultHi, Overflow, Zero
  );

  modport slave (
    input  Start, OperationSelect, A, B,
    output Ready, Done, Result, ResultHi, Overflow, Zero
  );
endinterface
`default_nettype wire

// File: rtl/srg_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module  : srg_iterative_alu
// Brief   : Clocked ALU; single-cycle logic/arith ops, iterative MULTU/DIVU.
// Revision: 1.0 - initial release
// ============================================================================
module srg_iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  srg_iterative_alu_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] c_op_and  = 3'b000;
  localparam logic [2:0] c_op_or   = 3'b001;
  localparam logic [2:0] c_op_add  = 3'b010;
  localparam logic [2:0] c_op_mult = 3'b011;
  localparam logic [2:0] c_op_div  = 3'b100;
  localparam logic [2:0] c_op_sub  = 3'b110;
  localparam logic [2:0] c_op_slt  = 3'b111;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b;
  logic               r_is_div, r_divz;
  logic               r_done, r_ovf, r_zero;
  logic [WIDTH-1:0]   r_result, r_result_hi;

  logic               w_ready, w_single, w_load_long, w_last;
  logic               w_is_sub, w_add_ovf;
  logic [WIDTH-1:0]   w_bop, w_sum, w_res;
  logic               w_ovf;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_iter_hi, w_iter_lo;

  always_ff @(posedge Clock) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_single     = 1'b0;
    w_load_long  = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.Start) begin
          if (bus.OperationSelect == c_op_mult || bus.OperationSelect == c_op_div) begin
            w_load_long  = 1'b1;
            w_state_next = S_RUN;
          end else begin
            w_single = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == c_last) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // SUB and SLT share the adder as A + ~B + 1; SLT corrects the sign with overflow
  always_comb begin
    w_is_sub  = bus.OperationSelect[2] & bus.OperationSelect[1];
    w_bop     = w_is_sub ? ~bus.B : bus.B;
    w_sum     = bus.A + w_bop + {{(WIDTH-1){1'b0}}, w_is_sub};
    w_add_ovf = (bus.A[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
    w_res     = '0;
    w_ovf     = 1'b0;
    case (bus.OperationSelect)
      c_op_and: w_res = bus.A & bus.B;
      c_op_or:  w_res = bus.A | bus.B;
      c_op_add, c_op_sub: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
      default:  w_res = '0;
    endcase
  end

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with
  // remainder in hi and quotient shifting into lo. Divide by zero naturally
  // yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = w_div_shift >= {1'b0, r_b};
    if (r_is_div) begin
      w_iter_hi = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_b) : w_div_shift[WIDTH-1:0];
      w_iter_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_iter_hi = w_mul_sum[WIDTH:1];
      w_iter_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_is_div    <= 1'b0;
      r_divz      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b1;
    end else begin
      r_done <= w_single | w_last;
      if (w_single) begin
        r_result    <= w_res;
        r_result_hi <= '0;
        r_ovf       <= w_ovf;
        r_zero      <= (w_res == '0);
      end
      if (w_load_long) begin
        r_hi     <= '0;
        r_lo     <= bus.A;
        r_b      <= bus.B;
        r_is_div <= (bus.OperationSelect == c_op_div);
        r_divz   <= (bus.B == '0);
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_hi  <= w_iter_hi;
        r_lo  <= w_iter_lo;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_result    <= w_iter_lo;
        r_result_hi <= w_iter_hi;
        r_ovf       <= r_is_div & r_divz;
        r_zero      <= (w_iter_lo == '0);
      end
    end
  end

  assign bus.Ready    = w_ready;
  assign bus.Done     = r_done;
  assign bus.Result   = r_result;
  assign bus.ResultHi = r_result_hi;
  assign bus.Overflow = r_ovf;
  assign bus.Zero     = r_zero;
endmodule
`default_nettype wire

// File: tb/tb_srg_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_srg_iterative_alu
// Brief   : Directed bench for 32-bit and 8-bit srg_iterative_alu instances.
// Revision: 1.0 - initial release
// ============================================================================
module tb_srg_iterative_alu;
  logic clk;
  logic rstn32, rstn8;
  int   n_tests = 0;
  int   n_fail  = 0;

  srg_iterative_alu_if #(.WIDTH(32)) b32();
  srg_iterative_alu_if #(.WIDTH(8))  b8();

  srg_iterative_alu #(.WIDTH(32)) dut32 (.Clock(clk), .Resetn(rstn32), .bus(b32.slave));
  srg_iterative_alu #(.WIDTH(8))  dut8  (.Clock(clk), .Resetn(rstn8),  .bus(b8.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t v[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic eovf,
                       input string nm);
    int lat;
    int bad;
    logic [31:0] prev;
    lat  = 0;
    bad  = 0;
    prev = b32.Result;
    b32.Start = 1'b1; b32.OperationSelect = op; b32.A = a; b32.B = b;
    @(negedge clk);
    b32.Start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (b32.Done) begin
        lat = c;
        break;
      end
      if (b32.Ready || b32.Result !== prev) bad++;
      // intruding request while busy must be ignored
      if (c == 5) begin
        b32.Start = 1'b1; b32.OperationSelect = 3'b000; b32.A = 32'h1; b32.B = 32'h2;
      end else begin
        b32.Start = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, " latency"}, 64'(lat), 64'd33);
    check({nm, " busy"}, 64'(bad), 64'd0);
    check({nm, " result"}, 64'(b32.Result), 64'(elo));
    check({nm, " resulthi"}, 64'(b32.ResultHi), 64'(ehi));
    check({nm, " overflow"}, 64'(b32.Overflow), 64'(eovf));
    check({nm, " zero"}, 64'(b32.Zero), 64'(elo == 32'h0));
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] elo, input logic [7:0] ehi, input string nm);
    int lat;
    lat = 0;
    b8.Start = 1'b1; b8.OperationSelect = op; b8.A = a; b8.B = b;
    @(negedge clk);
    b8.Start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (b8.Done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({nm, " latency"}, 64'(lat), 64'd9);
    check({nm, " result"}, 64'(b8.Result), 64'(elo));
    check({nm, " resulthi"}, 64'(b8.ResultHi), 64'(ehi));
  endtask

  initial begin
    int dones;
    v[0]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    v[1]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    v[2]  = '{3'b111, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b1};
    v[3]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    v[4]  = '{3'b001, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0};
    v[5]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
    v[6]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};
    v[7]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    v[8]  = '{3'b101, 32'h0000_0123, 32'h0000_0456, 32'h0000_0000, 1'b0, 1'b1};
    v[9]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1};
    v[10] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0};

    rstn32 = 1'b0; rstn8 = 1'b0;
    b32.Start = 1'b0; b32.OperationSelect = 3'b000; b32.A = '0; b32.B = '0;
    b8.Start  = 1'b0; b8.OperationSelect  = 3'b000; b8.A  = '0; b8.B  = '0;
    repeat (3) @(negedge clk);
    check("reset ready", 64'(b32.Ready), 64'd1);
    check("reset done", 64'(b32.Done), 64'd0);
    check("reset result", 64'(b32.Result), 64'd0);
    check("reset resulthi", 64'(b32.ResultHi), 64'd0);
    check("reset overflow", 64'(b32.Overflow), 64'd0);
    check("reset zero", 64'(b32.Zero), 64'd1);
    check("reset8 zero", 64'(b8.Zero), 64'd1);
    rstn32 = 1'b1; rstn8 = 1'b1;
    @(negedge clk);

    // back-to-back single-cycle ops, one per cycle
    for (int i = 0; i < 11; i++) begin
      b32.Start = 1'b1; b32.OperationSelect = v[i].op; b32.A = v[i].a; b32.B = v[i].b;
      @(negedge clk);
      check($sformatf("v%0d done", i), 64'(b32.Done), 64'd1);
      check($sformatf("v%0d ready", i), 64'(b32.Ready), 64'd1);
      check($sformatf("v%0d result", i), 64'(b32.Result), 64'(v[i].res));
      check($sformatf("v%0d resulthi", i), 64'(b32.ResultHi), 64'd0);
      check($sformatf("v%0d overflow", i), 64'(b32.Overflow), 64'(v[i].ovf));
      check($sformatf("v%0d zero", i), 64'(b32.Zero), 64'(v[i].zero));
    end
    b32.Start = 1'b0;
    @(negedge clk);
    check("done pulse ends", 64'(b32.Done), 64'd0);

    run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu max");
    run32(3'b100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "divu 100/7");
    run32(3'b100, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "divu by zero");

    // request in the Done cycle is accepted without a bubble
    b32.Start = 1'b1; b32.OperationSelect = 3'b010; b32.A = 32'd2; b32.B = 32'd2;
    @(negedge clk);
    b32.Start = 1'b0;
    check("nobubble done", 64'(b32.Done), 64'd1);
    check("nobubble result", 64'(b32.Result), 64'd4);
    check("nobubble resulthi", 64'(b32.ResultHi), 64'd0);

    // reset in the middle of a multiply
    b32.Start = 1'b1; b32.OperationSelect = 3'b011; b32.A = 32'hFFFF_FFFF; b32.B = 32'h3;
    @(negedge clk);
    b32.Start = 1'b0;
    repeat (9) @(negedge clk);
    rstn32 = 1'b0;
    @(negedge clk);
    rstn32 = 1'b1;
    check("abort ready", 64'(b32.Ready), 64'd1);
    check("abort result", 64'(b32.Result), 64'd0);
    check("abort zero", 64'(b32.Zero), 64'd1);
    check("abort done", 64'(b32.Done), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b32.Done) dones++;
    end
    check("abort no late done", 64'(dones), 64'd0);
    b32.Start = 1'b1; b32.OperationSelect = 3'b010; b32.A = 32'd3; b32.B = 32'd4;
    @(negedge clk);
    b32.Start = 1'b0;
    check("post-abort add", 64'(b32.Result), 64'd7);
    check("post-abort done", 64'(b32.Done), 64'd1);

    // 8-bit instance
    run8(3'b011, 8'hFF, 8'hFF, 8'h01, 8'hFE, "w8 multu");
    run8(3'b100, 8'd200, 8'd7, 8'd28, 8'd4, "w8 divu");
    b8.Start = 1'b1; b8.OperationSelect = 3'b110; b8.A = 8'h00; b8.B = 8'h01;
    @(negedge clk);
    b8.Start = 1'b0;
    check("w8 sub done", 64'(b8.Done), 64'd1);
    check("w8 sub result", 64'(b8.Result), 64'hFF);
    check("w8 sub overflow", 64'(b8.Overflow), 64'd0);
    check("w8 sub zero", 64'(b8.Zero), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
